// File: rtl/map_renderer.sv
// Three-stage tile-map pixel renderer: cell address, map read, colour register.
// Optional grid overlay enabled by defining GRID_LINES_EN.
module map_renderer (
  input  logic       clock_25,
  input  logic       reset_key,
  input  logic       video_on,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic [5:0] robot_row,
  input  logic [5:0] robot_column,
  input  logic [1:0] robot_orientation,
  output logic [7:0] map_addr,
  input  logic [2:0] map_data,
  output logic [7:0] graph_r,
  output logic [7:0] graph_g,
  output logic [7:0] graph_b
);

  localparam logic [23:0] COL_BLACK  = 24'h000000;
  localparam logic [23:0] COL_FLOOR  = 24'h202020;
  localparam logic [23:0] COL_WALL   = 24'h808080;
  localparam logic [23:0] COL_TRASH  = 24'h8B4513;
  localparam logic [23:0] COL_DIRT   = 24'h008000;
  localparam logic [23:0] COL_OTHER  = 24'hFF00FF;
  localparam logic [23:0] COL_ROBOT  = 24'hFFFF00;
  localparam logic [23:0] COL_MARKER = 24'hFF0000;
`ifdef GRID_LINES_EN
  localparam logic [23:0] COL_GRID   = 24'h404040;
`endif

  logic [5:0] cell_row, cell_col;
  logic       in_map, frame_start;

  logic [7:0] map_addr_d, map_addr_q;
  logic       s0_video_d, s0_video_q;
  logic       s0_map_d, s0_map_q;
  logic [5:0] s0_row_d, s0_row_q;
  logic [5:0] s0_col_d, s0_col_q;
  logic [4:0] s0_offx_d, s0_offx_q;
  logic [4:0] s0_offy_d, s0_offy_q;

  logic [5:0] frame_cnt_d, frame_cnt_q;
  logic [5:0] shadow_row_d, shadow_row_q;
  logic [5:0] shadow_col_d, shadow_col_q;
  logic [1:0] shadow_ori_d, shadow_ori_q;

  logic       robot_valid, robot_hit, x_mid, y_mid, marker_zone;
  logic       s1_video_d, s1_video_q;
  logic       s1_map_d, s1_map_q;
  logic       s1_robot_d, s1_robot_q;
  logic       s1_marker_d, s1_marker_q;
  logic       s1_blink_d, s1_blink_q;
`ifdef GRID_LINES_EN
  logic       s1_grid_d, s1_grid_q;
`endif

  logic [23:0] graph_d, graph_q;

  // Stage 0: cell address, sideband capture, and frame-start bookkeeping.
  always_comb begin
    cell_col    = {1'b0, pix_x[9:5]} + 6'd1;
    cell_row    = {1'b0, pix_y[9:5]} + 6'd1;
    in_map      = (pix_y < 10'd320);
    frame_start = (pix_x == 10'd0) && (pix_y == 10'd0);

    map_addr_d  = in_map ? (({2'b00, cell_row} * 8'd20) + {2'b00, cell_col}) : 8'd0;
    s0_video_d  = video_on;
    s0_map_d    = in_map;
    s0_row_d    = cell_row;
    s0_col_d    = cell_col;
    s0_offx_d   = pix_x[4:0];
    s0_offy_d   = pix_y[4:0];

    frame_cnt_d  = frame_cnt_q;
    shadow_row_d = shadow_row_q;
    shadow_col_d = shadow_col_q;
    shadow_ori_d = shadow_ori_q;
    if (frame_start) begin
      frame_cnt_d  = frame_cnt_q + 6'd1;
      shadow_row_d = robot_row;
      shadow_col_d = robot_column;
      shadow_ori_d = robot_orientation;
    end
  end

  // Stage 1 reads shadows after the frame-start update, so a whole frame sees one robot pose.
  always_comb begin
    robot_valid = (shadow_row_q >= 6'd1) && (shadow_row_q <= 6'd10) &&
                  (shadow_col_q >= 6'd1) && (shadow_col_q <= 6'd20);
    robot_hit   = s0_map_q && robot_valid &&
                  (s0_row_q == shadow_row_q) && (s0_col_q == shadow_col_q);
    x_mid       = (s0_offx_q >= 5'd12) && (s0_offx_q <= 5'd19);
    y_mid       = (s0_offy_q >= 5'd12) && (s0_offy_q <= 5'd19);

    marker_zone = 1'b0;
    case (shadow_ori_q)
      2'b00:   marker_zone = x_mid && (s0_offy_q <= 5'd7);
      2'b01:   marker_zone = x_mid && (s0_offy_q >= 5'd24);
      2'b10:   marker_zone = y_mid && (s0_offx_q >= 5'd24);
      default: marker_zone = y_mid && (s0_offx_q <= 5'd7);
    endcase

    s1_video_d  = s0_video_q;
    s1_map_d    = s0_map_q;
    s1_robot_d  = robot_hit;
    s1_marker_d = robot_hit && marker_zone;
    s1_blink_d  = frame_cnt_q[5];
`ifdef GRID_LINES_EN
    s1_grid_d   = (s0_offx_q == 5'd0) || (s0_offy_q == 5'd0);
`endif
  end

  // Stage 2: map_data is valid now and lines up with the stage-1 sideband.
  always_comb begin
    graph_d = COL_BLACK;
    if (s1_video_q && s1_map_q) begin
      if (s1_marker_q)
        graph_d = COL_MARKER;
      else if (s1_robot_q)
        graph_d = COL_ROBOT;
`ifdef GRID_LINES_EN
      else if (s1_grid_q)
        graph_d = COL_GRID;
`endif
      else begin
        case (map_data)
          3'd0:    graph_d = COL_FLOOR;
          3'd1:    graph_d = COL_WALL;
          3'd2:    graph_d = s1_blink_q ? COL_FLOOR : COL_TRASH;
          3'd7:    graph_d = COL_DIRT;
          default: graph_d = COL_OTHER;
        endcase
      end
    end
  end

  always_ff @(posedge clock_25 or negedge reset_key) begin
    if (!reset_key) begin
      map_addr_q   <= 8'd0;
      s0_video_q   <= 1'b0;
      s0_map_q     <= 1'b0;
      s0_row_q     <= 6'd0;
      s0_col_q     <= 6'd0;
      s0_offx_q    <= 5'd0;
      s0_offy_q    <= 5'd0;
      frame_cnt_q  <= 6'd0;
      shadow_row_q <= 6'd0;
      shadow_col_q <= 6'd0;
      shadow_ori_q <= 2'b00;
      s1_video_q   <= 1'b0;
      s1_map_q     <= 1'b0;
      s1_robot_q   <= 1'b0;
      s1_marker_q  <= 1'b0;
      s1_blink_q   <= 1'b0;
`ifdef GRID_LINES_EN
      s1_grid_q    <= 1'b0;
`endif
      graph_q      <= 24'd0;
    end else begin
      map_addr_q   <= map_addr_d;
      s0_video_q   <= s0_video_d;
      s0_map_q     <= s0_map_d;
      s0_row_q     <= s0_row_d;
      s0_col_q     <= s0_col_d;
      s0_offx_q    <= s0_offx_d;
      s0_offy_q    <= s0_offy_d;
      frame_cnt_q  <= frame_cnt_d;
      shadow_row_q <= shadow_row_d;
      shadow_col_q <= shadow_col_d;
      shadow_ori_q <= shadow_ori_d;
      s1_video_q   <= s1_video_d;
      s1_map_q     <= s1_map_d;
      s1_robot_q   <= s1_robot_d;
      s1_marker_q  <= s1_marker_d;
      s1_blink_q   <= s1_blink_d;
`ifdef GRID_LINES_EN
      s1_grid_q    <= s1_grid_d;
`endif
      graph_q      <= graph_d;
    end
  end

  assign map_addr = map_addr_q;
  assign graph_r  = graph_q[23:16];
  assign graph_g  = graph_q[15:8];
  assign graph_b  = graph_q[7:0];

endmodule

// File: tb/tb_map_renderer.sv
// Directed bench for map_renderer with a synchronous-read map memory model.
// Grid expectations follow GRID_LINES_EN, matching the design build.
module tb_map_renderer;

  localparam logic [23:0] BLACK  = 24'h000000;
  localparam logic [23:0] FLOOR  = 24'h202020;
  localparam logic [23:0] WALL   = 24'h808080;
  localparam logic [23:0] TRASH  = 24'h8B4513;
  localparam logic [23:0] DIRT   = 24'h008000;
  localparam logic [23:0] OTHER  = 24'hFF00FF;
  localparam logic [23:0] YELLOW = 24'hFFFF00;
  localparam logic [23:0] RED    = 24'hFF0000;

  logic       clock_25 = 1'b0;
  logic       reset_key;
  logic       video_on;
  logic [9:0] pix_x, pix_y;
  logic [5:0] robot_row, robot_column;
  logic [1:0] robot_orientation;
  logic [7:0] map_addr;
  logic [2:0] map_data;
  logic [7:0] graph_r, graph_g, graph_b;

  logic [2:0] mem [0:255];
  int checks = 0;
  int errors = 0;

  map_renderer dut (
    .clock_25(clock_25), .reset_key(reset_key), .video_on(video_on),
    .pix_x(pix_x), .pix_y(pix_y),
    .robot_row(robot_row), .robot_column(robot_column),
    .robot_orientation(robot_orientation),
    .map_addr(map_addr), .map_data(map_data),
    .graph_r(graph_r), .graph_g(graph_g), .graph_b(graph_b)
  );

  always #20 clock_25 = ~clock_25;

  // Map memory: registered read, data valid one clock after the address.
  always @(posedge clock_25) map_data <= mem[map_addr];

  function automatic logic [23:0] rgb();
    return {graph_r, graph_g, graph_b};
  endfunction

  task automatic drive(input logic [9:0] x, input logic [9:0] y, input logic v);
    pix_x = x;
    pix_y = y;
    video_on = v;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock_25);
      @(negedge clock_25);
    end
  endtask

  task automatic frame_starts(input int n);
    drive(10'd0, 10'd0, 1'b1);
    step(n);
    drive(10'd5, 10'd5, 1'b1);
  endtask

  task automatic test_reset;
    robot_row = 6'd1; robot_column = 6'd1; robot_orientation = 2'b00;
    drive(10'd10, 10'd10, 1'b1);
    step(4);
    checks++;
    if (rgb() !== BLACK) begin
      errors++; $display("[TB] FAIL reset_graph got %06h expected %06h", rgb(), BLACK);
    end
    checks++;
    if (map_addr !== 8'd0) begin
      errors++; $display("[TB] FAIL reset_addr got %0d expected 0", map_addr);
    end
    reset_key = 1'b1;
    step(3);
    checks++;
    if (rgb() !== WALL) begin
      errors++; $display("[TB] FAIL post_reset_hidden got %06h expected %06h", rgb(), WALL);
    end
    robot_row = 6'd0; robot_column = 6'd0;
  endtask

  task automatic check_pixel(input string name, input logic [9:0] x, input logic [9:0] y,
                             input logic v, input logic [23:0] exp);
    drive(x, y, v);
    step(3);
    checks++;
    if (rgb() !== exp) begin
      errors++; $display("[TB] FAIL %s got %06h expected %06h", name, rgb(), exp);
    end
  endtask

  task automatic test_blink;
    check_pixel("blink_cnt0", 10'd70, 10'd40, 1'b1, TRASH);
    frame_starts(31);
    check_pixel("blink_cnt31", 10'd70, 10'd40, 1'b1, TRASH);
    frame_starts(1);
    check_pixel("blink_cnt32", 10'd70, 10'd40, 1'b1, FLOOR);
    frame_starts(31);
    check_pixel("blink_cnt63", 10'd70, 10'd40, 1'b1, FLOOR);
    frame_starts(1);
    check_pixel("blink_wrap", 10'd70, 10'd40, 1'b1, TRASH);
  endtask

  task automatic test_wall;
    logic [23:0] exp;
`ifdef GRID_LINES_EN
    exp = 24'h404040;
`else
    exp = WALL;
`endif
    drive(10'd0, 10'd0, 1'b1);
    step(1);
    checks++;
    if (map_addr !== 8'd21) begin
      errors++; $display("[TB] FAIL wall_addr got %0d expected 21", map_addr);
    end
    drive(10'd5, 10'd5, 1'b1);
    step(2);
    checks++;
    if (rgb() !== exp) begin
      errors++; $display("[TB] FAIL wall_pixel got %06h expected %06h", rgb(), exp);
    end
  endtask

  task automatic test_cell_codes;
    check_pixel("code_other", 10'd140, 10'd40, 1'b1, OTHER);
    check_pixel("code_floor", 10'd40, 10'd10, 1'b1, FLOOR);
    check_pixel("code_dirt", 10'd140, 10'd10, 1'b1, DIRT);
  endtask

  task automatic test_blank;
    drive(10'd100, 10'd330, 1'b1);
    step(1);
    checks++;
    if (map_addr !== 8'd0) begin
      errors++; $display("[TB] FAIL offmap_addr got %0d expected 0", map_addr);
    end
    check_pixel("offmap_black", 10'd100, 10'd330, 1'b1, BLACK);
    check_pixel("video_off_black", 10'd140, 10'd40, 1'b0, BLACK);
  endtask

  task automatic test_robot;
    robot_row = 6'd3; robot_column = 6'd5; robot_orientation = 2'b10;
    frame_starts(1);
    check_pixel("east_marker", 10'd156, 10'd79, 1'b1, RED);
    check_pixel("robot_body", 10'd140, 10'd79, 1'b1, YELLOW);
    check_pixel("marker_x_edge", 10'd151, 10'd79, 1'b1, YELLOW);
    check_pixel("marker_x_first", 10'd152, 10'd79, 1'b1, RED);
    check_pixel("marker_y_edge", 10'd156, 10'd75, 1'b1, YELLOW);
    robot_column = 6'd6;
    check_pixel("no_tear_old", 10'd140, 10'd79, 1'b1, YELLOW);
    check_pixel("no_tear_new", 10'd172, 10'd79, 1'b1, FLOOR);
    frame_starts(1);
    check_pixel("moved_robot", 10'd172, 10'd79, 1'b1, YELLOW);
    check_pixel("moved_vacated", 10'd140, 10'd79, 1'b1, DIRT);
    robot_column = 6'd5; robot_orientation = 2'b00;
    frame_starts(1);
    check_pixel("north_marker", 10'd143, 10'd67, 1'b1, RED);
    check_pixel("north_east_body", 10'd156, 10'd79, 1'b1, YELLOW);
  endtask

  task automatic test_robot_invalid;
    robot_row = 6'd11; robot_column = 6'd5;
    frame_starts(1);
    check_pixel("row11_hidden", 10'd140, 10'd79, 1'b1, DIRT);
    robot_row = 6'd1; robot_column = 6'd21;
    frame_starts(1);
    check_pixel("col21_hidden", 10'd650, 10'd10, 1'b1, FLOOR);
    robot_row = 6'd10; robot_column = 6'd20; robot_orientation = 2'b00;
    frame_starts(1);
    check_pixel("corner_robot", 10'd620, 10'd300, 1'b1, YELLOW);
  endtask

  task automatic test_grid;
`ifdef GRID_LINES_EN
    check_pixel("grid_line", 10'd32, 10'd40, 1'b1, 24'h404040);
`else
    check_pixel("grid_line", 10'd32, 10'd40, 1'b1, FLOOR);
`endif
  endtask

  task automatic test_back_to_back;
    logic [9:0]  px [0:5];
    logic [9:0]  py [0:5];
    logic        pv [0:5];
    logic [23:0] ex [0:5];
    px = '{10'd10, 10'd100, 10'd40, 10'd140, 10'd140, 10'd140};
    py = '{10'd10, 10'd330, 10'd10, 10'd40, 10'd10, 10'd10};
    pv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    ex = '{WALL, BLACK, FLOOR, OTHER, BLACK, DIRT};
    for (int i = 0; i < 8; i++) begin
      if (i < 6) drive(px[i], py[i], pv[i]);
      step(1);
      if (i >= 2) begin
        checks++;
        if (rgb() !== ex[i-2]) begin
          errors++;
          $display("[TB] FAIL stream_%0d got %06h expected %06h", i - 2, rgb(), ex[i-2]);
        end
      end
    end
  endtask

  task automatic test_reset_midframe;
    robot_row = 6'd3; robot_column = 6'd5; robot_orientation = 2'b10;
    frame_starts(1);
    check_pixel("pre_reset_robot", 10'd140, 10'd79, 1'b1, YELLOW);
    #3 reset_key = 1'b0;
    #1;
    checks++;
    if (rgb() !== BLACK) begin
      errors++; $display("[TB] FAIL async_reset_graph got %06h expected %06h", rgb(), BLACK);
    end
    checks++;
    if (map_addr !== 8'd0) begin
      errors++; $display("[TB] FAIL async_reset_addr got %0d expected 0", map_addr);
    end
    @(negedge clock_25);
    step(2);
    reset_key = 1'b1;
    check_pixel("reset_robot_hidden", 10'd140, 10'd79, 1'b1, DIRT);
    frame_starts(1);
    check_pixel("reset_robot_back", 10'd140, 10'd79, 1'b1, YELLOW);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 3'd0;
    mem[21] = 3'd1;
    mem[43] = 3'd2;
    mem[45] = 3'd5;
    mem[25] = 3'd7;
    mem[65] = 3'd7;
    reset_key = 1'b0;
    video_on = 1'b0;
    pix_x = 10'd0; pix_y = 10'd0;
    robot_row = 6'd0; robot_column = 6'd0; robot_orientation = 2'b00;
    @(negedge clock_25);
    test_reset;
    test_blink;
    test_wall;
    test_cell_codes;
    test_blank;
    test_robot;
    test_robot_invalid;
    test_grid;
    test_back_to_back;
    test_reset_midframe;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
